// File: rtl/scc_delta_sigma_dac_if.sv
// Mixer-to-DAC bundle: phase and level from the SCC mixer plus mute in; ready and bitstream out.
interface scc_delta_sigma_dac_if;
  logic [2:0]  active;
  logic [10:0] level_in;
  logic        mute;
  logic        ready;
  logic        dac_out;

  modport master (output active, level_in, mute, input ready, dac_out);
  modport slave  (input active, level_in, mute, output ready, dac_out);
endinterface

// File: rtl/scc_delta_sigma_dac.sv
// SCC output stage: phase-4 capture, pop-free mute/ramp FSM, optional IIR (SCC_DAC_LPF_EN), 1-bit delta-sigma.
// Latency 2 clk from capture edge to dac_out without the IIR; no backpressure, level sampled once per round.
module scc_delta_sigma_dac #(
  parameter int filter_shift = 3,
  parameter int midscale     = 1024
) (
  input logic                 clk,
  input logic                 nreset,
  scc_delta_sigma_dac_if.slave bus
);

  typedef enum logic [1:0] {ST_RAMP_UP, ST_RUN, ST_RAMP_DOWN, ST_MUTED} state_t;

  localparam logic [10:0] MID    = 11'(midscale);
  localparam logic [10:0] MID_M1 = 11'(midscale - 1);

  state_t      state, state_nxt;
  logic [10:0] ff_sample;
  logic [10:0] ff_ramp, ramp_nxt;
  logic [10:0] x, y;
  logic [11:0] ff_acc;
  logic [11:0] acc_sum;
  logic        ff_dac;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ff_sample <= '0;
    end else if (bus.active == 3'd4) begin
      ff_sample <= bus.level_in;
    end
  end

  assign x = (state == ST_RUN) ? ff_sample : ff_ramp;

`ifdef SCC_DAC_LPF_EN
  localparam int LW = 11 + filter_shift;
  logic [LW-1:0] ff_lpf;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ff_lpf <= '0;
    end else begin
      ff_lpf <= ff_lpf + LW'(x) - (ff_lpf >> filter_shift);
    end
  end

  assign y = ff_lpf[10+filter_shift:filter_shift];
`else
  assign y = x;
`endif

  always_comb begin
    state_nxt = state;
    ramp_nxt  = ff_ramp;
    case (state)
      ST_RAMP_UP: begin
        // Resuming above midscale wraps through 2047 -> 0 before landing on midscale.
        if (bus.mute) begin
          state_nxt = ST_RAMP_DOWN;
        end else if (ff_ramp == MID_M1) begin
          ramp_nxt  = MID;
          state_nxt = ST_RUN;
        end else begin
          ramp_nxt = ff_ramp + 11'd1;
        end
      end
      ST_RUN: begin
        if (bus.mute) begin
          ramp_nxt  = y;
          state_nxt = ST_RAMP_DOWN;
        end
      end
      ST_RAMP_DOWN: begin
        if (!bus.mute) begin
          state_nxt = ST_RAMP_UP;
        end else if (ff_ramp == 11'd0) begin
          state_nxt = ST_MUTED;
        end else begin
          ramp_nxt = ff_ramp - 11'd1;
        end
      end
      ST_MUTED: begin
        ramp_nxt = '0;
        if (!bus.mute) begin
          state_nxt = ST_RAMP_UP;
        end
      end
      default: begin
        state_nxt = ST_RAMP_UP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= ST_RAMP_UP;
      ff_ramp <= '0;
    end else begin
      state   <= state_nxt;
      ff_ramp <= ramp_nxt;
    end
  end

  // Bit 11 of ff_acc is the registered carry; dac_out is one more stage behind it.
  assign acc_sum = {1'b0, ff_acc[10:0]} + {1'b0, y};

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ff_acc <= '0;
      ff_dac <= 1'b0;
    end else begin
      ff_acc <= (state == ST_MUTED) ? 12'd0 : acc_sum;
      ff_dac <= (state == ST_MUTED || state_nxt == ST_MUTED) ? 1'b0 : ff_acc[11];
    end
  end

  assign bus.ready   = (state == ST_RUN);
  assign bus.dac_out = ff_dac;

endmodule

// File: tb/tb_scc_delta_sigma_dac.sv
// Randomized self-checking bench for scc_delta_sigma_dac against an arithmetic model of ramp timing and bit density.
module tb_scc_delta_sigma_dac;
  localparam int MIDSCALE = 1024;
  localparam int SETTLE   = 300;

  logic clk    = 1'b0;
  logic nreset = 1'b1;
  bit   auto_phase = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  scc_delta_sigma_dac_if bus();

  scc_delta_sigma_dac #(.filter_shift(3), .midscale(MIDSCALE)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change 1 time unit after the edge, outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_phase) bus.active = bus.active + 3'd1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic count_ones(output int ones);
    ones = 0;
    for (int i = 0; i < 2048; i++) begin
      tick();
      if (bus.dac_out === 1'b1) ones++;
    end
  endtask

  task automatic wait_ready(input int limit, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (bus.ready !== 1'b1 && cnt < limit);
  endtask

  task automatic test_reset();
    int cnt;
    bus.active   = 3'd0;
    bus.level_in = 11'd1024;
    bus.mute     = 1'b0;
    #2 nreset = 1'b0;
    #1;
    n_checks++;
    if (bus.ready !== 1'b0) $display("FAIL reset_ready got %b want 0", bus.ready);
    else n_pass++;
    n_checks++;
    if (bus.dac_out !== 1'b0) $display("FAIL reset_dac got %b want 0", bus.dac_out);
    else n_pass++;
    settle(3);
    nreset = 1'b1;
    wait_ready(3000, cnt);
    n_checks++;
    if (cnt != MIDSCALE) $display("FAIL reset_rampup_clks got %0d want %0d", cnt, MIDSCALE);
    else n_pass++;
  endtask

  // Steady state: over 2048 clocks the carry count equals the level exactly.
  task automatic test_level(input logic [10:0] lv, input int tol, input string name);
    int ones, diff;
    bus.level_in = lv;
    settle(SETTLE);
    count_ones(ones);
    diff = ones - int'(lv);
    if (diff < 0) diff = -diff;
    n_checks++;
    if (diff > tol) $display("FAIL %s ones got %0d want %0d (+-%0d)", name, ones, lv, tol);
    else n_pass++;
  endtask

  task automatic test_random_levels();
    logic [10:0] lv;
    for (int k = 0; k < 3; k++) begin
      lv = 11'($urandom_range(2047, 0));
      test_level(lv, 0, "random_density");
    end
  endtask

  task automatic test_capture();
    int phases[7];
    int shortround[6];
    logic [10:0] exp_s, v;
    phases     = '{0, 1, 2, 3, 5, 6, 7};
    shortround = '{0, 1, 2, 3, 4, 0};
    auto_phase = 1'b0;
    exp_s = 11'($urandom_range(2047, 0));
    bus.active = 3'd4; bus.level_in = exp_s;
    tick();
    n_checks++;
    if (dut.ff_sample !== exp_s) $display("FAIL capture_ph4 got %0d want %0d", dut.ff_sample, exp_s);
    else n_pass++;
    for (int i = 0; i < 7; i++) begin
      bus.active   = 3'(phases[i]);
      bus.level_in = exp_s ^ 11'($urandom_range(2047, 1));
      tick();
      n_checks++;
      if (dut.ff_sample !== exp_s)
        $display("FAIL capture_hold_ph%0d got %0d want %0d", phases[i], dut.ff_sample, exp_s);
      else n_pass++;
    end
    for (int i = 0; i < 6; i++) begin
      v = 11'($urandom_range(2047, 0));
      bus.active   = 3'(shortround[i]);
      bus.level_in = v;
      if (shortround[i] == 4) exp_s = v;
      tick();
      n_checks++;
      if (dut.ff_sample !== exp_s)
        $display("FAIL capture_short_step%0d got %0d want %0d", i, dut.ff_sample, exp_s);
      else n_pass++;
    end
    bus.active = 3'd0;
    auto_phase = 1'b1;
  endtask

  task automatic test_mute();
    int cnt, ones;
    bus.level_in = 11'd1536;
    settle(SETTLE);
    n_checks++;
    if (bus.ready !== 1'b1) $display("FAIL mute_pre_ready got %b want 1", bus.ready);
    else n_pass++;
    bus.mute = 1'b1;
    tick();
    n_checks++;
    if (bus.ready !== 1'b0) $display("FAIL mute_ready_fall got %b want 0", bus.ready);
    else n_pass++;
    n_checks++;
    if (dut.ff_ramp !== 11'd1536) $display("FAIL mute_ramp_start got %0d want 1536", dut.ff_ramp);
    else n_pass++;
    cnt = 0;
    while (dut.ff_ramp != 11'd0 && cnt < 4000) begin
      tick();
      cnt++;
    end
    n_checks++;
    if (cnt != 1536) $display("FAIL mute_rampdown_clks got %0d want 1536", cnt);
    else n_pass++;
    ones = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.dac_out !== 1'b0) ones++;
    end
    n_checks++;
    if (ones != 0) $display("FAIL muted_dac_ones got %0d want 0", ones);
    else n_pass++;
    n_checks++;
    if (dut.ff_acc !== 12'd0) $display("FAIL muted_acc got %0d want 0", dut.ff_acc);
    else n_pass++;
  endtask

  task automatic test_unmute_from_muted();
    int cnt;
    bus.level_in = 11'd1024;
    bus.mute = 1'b0;
    wait_ready(3000, cnt);
    n_checks++;
    if (cnt != MIDSCALE + 1) $display("FAIL unmute_muted_clks got %0d want %0d", cnt, MIDSCALE + 1);
    else n_pass++;
  endtask

  task automatic test_unmute_mid_ramp();
    int cnt;
    settle(SETTLE);
    bus.mute = 1'b1;
    tick();
    n_checks++;
    if (dut.ff_ramp !== 11'd1024) $display("FAIL midramp_start got %0d want 1024", dut.ff_ramp);
    else n_pass++;
    cnt = 0;
    while (dut.ff_ramp != 11'd500 && cnt < 2100) begin
      tick();
      cnt++;
    end
    n_checks++;
    if (cnt != 1024 - 500) $display("FAIL midramp_down_clks got %0d want %0d", cnt, 1024 - 500);
    else n_pass++;
    bus.mute = 1'b0;
    tick();
    n_checks++;
    if (dut.ff_ramp !== 11'd500) $display("FAIL midramp_hold got %0d want 500", dut.ff_ramp);
    else n_pass++;
    wait_ready(3000, cnt);
    n_checks++;
    if (cnt != MIDSCALE - 500) $display("FAIL midramp_up_clks got %0d want %0d", cnt, MIDSCALE - 500);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int cnt;
    bus.level_in = 11'd2047;
    settle(SETTLE);
    nreset = 1'b0;
    #1;
    n_checks++;
    if (bus.ready !== 1'b0) $display("FAIL midrst_ready got %b want 0", bus.ready);
    else n_pass++;
    n_checks++;
    if (bus.dac_out !== 1'b0) $display("FAIL midrst_dac got %b want 0", bus.dac_out);
    else n_pass++;
    #2 nreset = 1'b1;
    wait_ready(3000, cnt);
    n_checks++;
    if (cnt != MIDSCALE) $display("FAIL midrst_rampup_clks got %0d want %0d", cnt, MIDSCALE);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_level(11'd1024, 1, "density_mid");
    test_level(11'd0,    0, "density_zero");
    test_level(11'd2047, 0, "density_full");
    test_random_levels();
    test_capture();
    test_mute();
    test_unmute_from_muted();
    test_unmute_mid_ramp();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
